vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single video-side VRAM port (16-bit words, 8K deep) between two requesters: the line renderer, which fetches words, and the CPU data-port path, which does byte writes and read-ahead byte reads.
- The renderer has priority. A starvation counter guarantees the CPU a slot within a bounded time.
- Emulates the VDP read buffer: every CPU access, read or write, refreshes the byte returned on the next data-port read.

Parameters:
MAX_WAIT, 16, max consecutive renderer grants while a CPU access is pending before the CPU is forced in (range 1-255).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cpu_addr  in  14  CPU byte address; [13:1] selects the word, [0] selects the lane (0 = [7:0], 1 = [15:8])
cpu_wrdata  in  8  CPU write byte
cpu_wr_req  in  1  single-cycle write request
cpu_rd_req  in  1  single-cycle read-ahead request
cpu_busy  out  1  a CPU access is pending
cpu_rddata  out  8  read buffer
cpu_rd_valid  out  1  one-cycle pulse when cpu_rddata is updated
cpu_overrun  out  1  sticky; set when a request is dropped
overrun_clr  in  1  clears cpu_overrun
gfx_req  in  1  renderer request, level; held until acked
gfx_addr  in  13  renderer word address
gfx_ack  out  1  grant, one pulse per accepted word
gfx_rddata  out  16  renderer read data
gfx_rddata_valid  out  1  one-cycle pulse
ram_addr  out  13  VRAM word address
ram_wrdata  out  16  VRAM write data (byte replicated on both lanes)
ram_be  out  2  VRAM byte enables
ram_wren  out  1  VRAM write strobe
ram_rddata  in  16  VRAM read data, valid the cycle after the address

Behaviour:
- All outputs are registered.
- Reset (reset_n low at a clk edge) values:
  - cpu_busy=0, cpu_rddata=0, cpu_rd_valid=0, cpu_overrun=0;
  - gfx_ack=0, gfx_rddata=0, gfx_rddata_valid=0;
  - ram_wren=0, ram_be=0, ram_addr=0;
  - pending entry cleared, wait_cnt=0, pipeline valids cleared.
- Reset mid-operation abandons any in-flight access. No valid pulse follows it.
- CPU pending entry (single slot: type, addr, data):
  - A request is captured when cpu_busy=0. cpu_busy rises the next cycle.
  - wr_req and rd_req in the same cycle: the write is captured, the read is dropped, cpu_overrun is set.
  - A request arriving while cpu_busy=1 is dropped and cpu_overrun is set.
  - overrun_clr has priority over a same-cycle set.
- Slot decision, made every cycle. Exactly one of the following happens:
  - FORCE_CPU: CPU pending and wait_cnt==MAX_WAIT.
  - GFX: gfx_req=1 and not FORCE_CPU. gfx_ack=1 that cycle, and wait_cnt increments if CPU is pending.
  - CPU: CPU pending and gfx_req=0 (or FORCE_CPU). gfx_ack=0, wait_cnt is cleared.
  - IDLE: no requests. ram_wren=0, ram_addr holds.
- Issue stage, driven on the cycle after the decision (cycle t+1):
  - GFX slot: ram_addr=gfx_addr sampled at grant.
  - CPU write: ram_addr=addr[13:1], ram_wrdata={data,data}, ram_be=addr[0]?2'b10:2'b01, ram_wren=1.
  - CPU read: ram_addr=addr[13:1], ram_wren=0, ram_be=0.
- Completion:
  - GFX: ram_rddata is registered into gfx_rddata at t+2, with gfx_rddata_valid=1 at t+2.
  - CPU read: the selected lane of ram_rddata is registered into cpu_rddata at t+2, with cpu_rd_valid=1. cpu_busy falls at t+2.
  - CPU write: cpu_rddata<=written byte and cpu_rd_valid=1 at t+2. cpu_busy falls at t+2.
  - A new CPU request is accepted from the cycle cpu_busy reads 0.
- Throughput:
  - Back-to-back renderer words are accepted one per cycle.
  - The pipeline is fully overlapped, so at most one access is issued per cycle.
- Renderer hazard: a forced CPU slot inserts a one-cycle gfx_ack gap. The renderer must tolerate a non-contiguous ack.
- wait_cnt saturates at MAX_WAIT. It is cleared when no CPU access is pending.

Test Plan:
1. Reset with all inputs active (gfx_req=1, cpu_wr_req=1) for 3 cycles -> all outputs 0 throughout.
2. CPU write only: cpu_addr=0x0123, data=0xA5 -> ram_addr=0x091, ram_be=10, ram_wrdata=0xA5A5, ram_wren=1 at t+1; cpu_rddata=0xA5, cpu_rd_valid at t+2, cpu_busy low at t+2.
3. CPU read: model word 0x0040 holds 0xBEEF; rd at addr 0x0080 -> cpu_rddata=0xEF; rd at addr 0x0081 -> cpu_rddata=0xBE, each with one cpu_rd_valid pulse.
4. Renderer burst of 40 words (gfx_req held high) with a CPU write pending from cycle 0, MAX_WAIT=16 -> gfx_ack high for 16 cycles, low for 1 (CPU write issued), then resumes. All 40 gfx_rddata values match the model in order.
5. Overrun: cpu_wr_req while cpu_busy=1 -> write dropped (VRAM unchanged), cpu_overrun=1 sticky until overrun_clr. Simultaneous rd_req+wr_req -> only the write occurs, cpu_overrun=1.
6. Reset asserted at t+1 of a CPU read -> no cpu_rd_valid, cpu_busy=0 after reset; the next read completes normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester VRAM port arbiter with VDP-style read buffer
//
// Shares one 16-bit x 8K video-side VRAM port between the line renderer and
// the CPU data-port path. The renderer has priority. A starvation counter
// forces the CPU in after MAX_WAIT consecutive renderer grants.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cpu_addr/cpu_wrdata     CPU byte address ([13:1] word, [0] lane) and write byte
//   cpu_wr_req/cpu_rd_req   single-cycle CPU write / read-ahead requests
//   cpu_busy                a CPU access is pending or in flight
//   cpu_rddata/cpu_rd_valid read buffer and its one-cycle update pulse
//   cpu_overrun/overrun_clr sticky dropped-request flag and its clear
//   gfx_req/gfx_addr        renderer word request (level) and word address
//   gfx_ack                 one pulse per granted renderer word
//   gfx_rddata(_valid)      renderer read data and its one-cycle pulse
//   ram_*                   VRAM port; ram_rddata is valid the cycle after ram_addr
//
// Timing, with the slot decided in cycle t: ram_* and gfx_ack are visible in
// t+1, ram_rddata returns in t+2 and is registered at the end of t+2.

module vram_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    input  logic        cpu_wr_req,
    input  logic        cpu_rd_req,
    output logic        cpu_busy,
    output logic [7:0]  cpu_rddata,
    output logic        cpu_rd_valid,
    output logic        cpu_overrun,
    input  logic        overrun_clr,
    input  logic        gfx_req,
    input  logic [12:0] gfx_addr,
    output logic        gfx_ack,
    output logic [15:0] gfx_rddata,
    output logic        gfx_rddata_valid,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_wrdata,
    output logic [1:0]  ram_be,
    output logic        ram_wren,
    input  logic [15:0] ram_rddata
);

    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_GFX  = 2'd1;
    localparam logic [1:0] SLOT_CPU  = 2'd2;
    localparam logic [7:0] MAX_W     = 8'(MAX_WAIT);

    // Pending CPU entry and bookkeeping
    logic        pend_valid_q, pend_valid_d;
    logic        pend_wr_q, pend_wr_d;
    logic [13:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    // Issue stage (visible in t+1)
    logic        gfx_ack_q, gfx_ack_d;
    logic        iss_rd_q, iss_rd_d;
    logic        iss_wr_q, iss_wr_d;
    logic        iss_lane_q, iss_lane_d;
    logic [7:0]  iss_data_q, iss_data_d;
    logic [12:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wrdata_q, ram_wrdata_d;
    logic [1:0]  ram_be_q, ram_be_d;
    logic        ram_wren_q, ram_wren_d;

    // Return stage (visible in t+2, while ram_rddata is valid)
    logic        ret_gfx_q, ret_gfx_d;
    logic        ret_rd_q, ret_rd_d;
    logic        ret_wr_q, ret_wr_d;
    logic        ret_lane_q, ret_lane_d;
    logic [7:0]  ret_data_q, ret_data_d;

    // Outputs
    logic [7:0]  cpu_rddata_q, cpu_rddata_d;
    logic        cpu_rd_valid_q, cpu_rd_valid_d;
    logic [15:0] gfx_rddata_q, gfx_rddata_d;
    logic        gfx_rddata_valid_q, gfx_rddata_valid_d;

    logic [1:0]  slot;
    logic        force_cpu;
    logic        capture;
    logic        drop;

    always_comb begin
        force_cpu = pend_valid_q && (wait_cnt_q == MAX_W);
        if (gfx_req && !force_cpu)
            slot = SLOT_GFX;
        else if (pend_valid_q)
            slot = SLOT_CPU;
        else
            slot = SLOT_IDLE;

        // cpu_busy covers the whole life of an access, so a second request
        // is always dropped rather than queued.
        capture = !busy_q && (cpu_wr_req || cpu_rd_req);
        drop    = (busy_q && (cpu_wr_req || cpu_rd_req)) ||
                  (!busy_q && cpu_wr_req && cpu_rd_req);
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        wait_cnt_d   = wait_cnt_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;

        if (capture) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = cpu_wr_req;
            pend_addr_d  = cpu_addr;
            pend_data_d  = cpu_wrdata;
            busy_d       = 1'b1;
        end
        if (slot == SLOT_CPU)
            pend_valid_d = 1'b0;
        if (ret_rd_q || ret_wr_q)
            busy_d = 1'b0;

        if (!pend_valid_q || slot == SLOT_CPU)
            wait_cnt_d = 8'd0;
        else if (slot == SLOT_GFX && wait_cnt_q != MAX_W)
            wait_cnt_d = wait_cnt_q + 8'd1;

        if (drop)
            overrun_d = 1'b1;
        if (overrun_clr)
            overrun_d = 1'b0;
    end

    always_comb begin
        gfx_ack_d    = (slot == SLOT_GFX);
        iss_rd_d     = (slot == SLOT_CPU) && !pend_wr_q;
        iss_wr_d     = (slot == SLOT_CPU) && pend_wr_q;
        iss_lane_d   = pend_addr_q[0];
        iss_data_d   = pend_data_q;
        ram_addr_d   = ram_addr_q;
        ram_wrdata_d = ram_wrdata_q;
        ram_be_d     = 2'b00;
        ram_wren_d   = 1'b0;

        if (slot == SLOT_GFX) begin
            ram_addr_d = gfx_addr;
        end else if (slot == SLOT_CPU) begin
            ram_addr_d = pend_addr_q[13:1];
            if (pend_wr_q) begin
                ram_wrdata_d = {pend_data_q, pend_data_q};
                ram_be_d     = pend_addr_q[0] ? 2'b10 : 2'b01;
                ram_wren_d   = 1'b1;
            end
        end

        ret_gfx_d  = gfx_ack_q;
        ret_rd_d   = iss_rd_q;
        ret_wr_d   = iss_wr_q;
        ret_lane_d = iss_lane_q;
        ret_data_d = iss_data_q;

        gfx_rddata_d       = gfx_rddata_q;
        gfx_rddata_valid_d = ret_gfx_q;
        if (ret_gfx_q)
            gfx_rddata_d = ram_rddata;

        // Both reads and writes refresh the read buffer.
        cpu_rddata_d   = cpu_rddata_q;
        cpu_rd_valid_d = ret_rd_q || ret_wr_q;
        if (ret_rd_q)
            cpu_rddata_d = ret_lane_q ? ram_rddata[15:8] : ram_rddata[7:0];
        else if (ret_wr_q)
            cpu_rddata_d = ret_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q       <= 1'b0;
            pend_wr_q          <= 1'b0;
            pend_addr_q        <= 14'd0;
            pend_data_q        <= 8'd0;
            wait_cnt_q         <= 8'd0;
            busy_q             <= 1'b0;
            overrun_q          <= 1'b0;
            gfx_ack_q          <= 1'b0;
            iss_rd_q           <= 1'b0;
            iss_wr_q           <= 1'b0;
            iss_lane_q         <= 1'b0;
            iss_data_q         <= 8'd0;
            ram_addr_q         <= 13'd0;
            ram_wrdata_q       <= 16'd0;
            ram_be_q           <= 2'b00;
            ram_wren_q         <= 1'b0;
            ret_gfx_q          <= 1'b0;
            ret_rd_q           <= 1'b0;
            ret_wr_q           <= 1'b0;
            ret_lane_q         <= 1'b0;
            ret_data_q         <= 8'd0;
            cpu_rddata_q       <= 8'd0;
            cpu_rd_valid_q     <= 1'b0;
            gfx_rddata_q       <= 16'd0;
            gfx_rddata_valid_q <= 1'b0;
        end else begin
            pend_valid_q       <= pend_valid_d;
            pend_wr_q          <= pend_wr_d;
            pend_addr_q        <= pend_addr_d;
            pend_data_q        <= pend_data_d;
            wait_cnt_q         <= wait_cnt_d;
            busy_q             <= busy_d;
            overrun_q          <= overrun_d;
            gfx_ack_q          <= gfx_ack_d;
            iss_rd_q           <= iss_rd_d;
            iss_wr_q           <= iss_wr_d;
            iss_lane_q         <= iss_lane_d;
            iss_data_q         <= iss_data_d;
            ram_addr_q         <= ram_addr_d;
            ram_wrdata_q       <= ram_wrdata_d;
            ram_be_q           <= ram_be_d;
            ram_wren_q         <= ram_wren_d;
            ret_gfx_q          <= ret_gfx_d;
            ret_rd_q           <= ret_rd_d;
            ret_wr_q           <= ret_wr_d;
            ret_lane_q         <= ret_lane_d;
            ret_data_q         <= ret_data_d;
            cpu_rddata_q       <= cpu_rddata_d;
            cpu_rd_valid_q     <= cpu_rd_valid_d;
            gfx_rddata_q       <= gfx_rddata_d;
            gfx_rddata_valid_q <= gfx_rddata_valid_d;
        end
    end

    assign cpu_busy         = busy_q;
    assign cpu_rddata       = cpu_rddata_q;
    assign cpu_rd_valid     = cpu_rd_valid_q;
    assign cpu_overrun      = overrun_q;
    assign gfx_ack          = gfx_ack_q;
    assign gfx_rddata       = gfx_rddata_q;
    assign gfx_rddata_valid = gfx_rddata_valid_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wrdata       = ram_wrdata_q;
    assign ram_be           = ram_be_q;
    assign ram_wren         = ram_wren_q;

endmodule
